// File: rtl/writeback_queue.sv
// Writeback receive queue: buffers up to two GPR writes per beat, drains one per cycle, holds CR.
// Optional macro WB_FORWARD_EN adds a combinational lookup of the youngest queued write.
module writeback_queue #(
  parameter int unsigned regWidth  = 5,
  parameter int unsigned dataWidth = 64,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned PTR_WIDTH = 3
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic [2:0]             functionalUnitCode_i,
  input  logic                   reg1WritebackEnable_i,
  input  logic                   reg2WritebackEnable_i,
  input  logic [regWidth-1:0]    reg1WritebackAddress_i,
  input  logic [regWidth-1:0]    reg2WritebackAddress_i,
  input  logic [dataWidth-1:0]   reg1WritebackVal_i,
  input  logic [dataWidth-1:0]   reg2WritebackVal_i,
  input  logic                   condRegUpdateEnable_i,
  input  logic [32:63]           newCRVal_i,
`ifdef WB_FORWARD_EN
  input  logic [regWidth-1:0]    fwdAddress_i,
  output logic                   fwdHit_o,
  output logic [dataWidth-1:0]   fwdVal_o,
`endif
  output logic                   stall_o,
  output logic                   regWriteEnable_o,
  output logic [regWidth-1:0]    regWriteAddress_o,
  output logic [dataWidth-1:0]   regWriteVal_o,
  output logic [32:63]           condReg_o,
  output logic [PTR_WIDTH:0]     queueCount_o
);

  localparam int unsigned EntryW = regWidth + dataWidth;
  localparam int unsigned CountW = PTR_WIDTH + 1;

  logic [EntryW-1:0]    mem_q [DEPTH];
  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CountW-1:0]    count_q, count_d, remain;
  logic                 accept, pop, push_a, push_b;
  logic [EntryW-1:0]    first_entry, second_entry, next_head;

  // Producer code carries no ordering information.
  logic unused_fu;
  assign unused_fu = ^functionalUnitCode_i;

  assign stall_o      = count_q > CountW'(DEPTH - 2);
  assign queueCount_o = count_q;

  always_comb begin
    accept       = !stall_o;
    push_a       = accept && (reg1WritebackEnable_i || reg2WritebackEnable_i);
    push_b       = accept && reg1WritebackEnable_i && reg2WritebackEnable_i;
    first_entry  = reg1WritebackEnable_i ? {reg1WritebackAddress_i, reg1WritebackVal_i}
                                         : {reg2WritebackAddress_i, reg2WritebackVal_i};
    second_entry = {reg2WritebackAddress_i, reg2WritebackVal_i};
    pop          = count_q != '0;
    rd_ptr_d     = rd_ptr_q + PTR_WIDTH'(pop);
    wr_ptr_d     = wr_ptr_q + PTR_WIDTH'(push_a) + PTR_WIDTH'(push_b);
    remain       = count_q - CountW'(pop);
    count_d      = remain + CountW'(push_a) + CountW'(push_b);
    // When nothing older survives the pop, the new head is this beat's first write.
    next_head    = (remain != '0) ? mem_q[rd_ptr_d] : first_entry;
  end

  always_ff @(posedge clock_i) begin
    if (push_a) mem_q[wr_ptr_q] <= first_entry;
    if (push_b) mem_q[wr_ptr_q + PTR_WIDTH'(1)] <= second_entry;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rd_ptr_q          <= '0;
      wr_ptr_q          <= '0;
      count_q           <= '0;
      regWriteEnable_o  <= 1'b0;
      regWriteAddress_o <= '0;
      regWriteVal_o     <= '0;
      condReg_o         <= '0;
    end else begin
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
      count_q          <= count_d;
      regWriteEnable_o <= count_d != '0;
      if (count_d != '0) {regWriteAddress_o, regWriteVal_o} <= next_head;
      if (accept && condRegUpdateEnable_i) condReg_o <= newCRVal_i;
    end
  end

`ifdef WB_FORWARD_EN
  // Later matches overwrite earlier ones, so the youngest queued entry wins.
  always_comb begin
    fwdHit_o = 1'b0;
    fwdVal_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CountW'(i) < count_q &&
          mem_q[rd_ptr_q + PTR_WIDTH'(i)][EntryW-1:dataWidth] == fwdAddress_i) begin
        fwdHit_o = 1'b1;
        fwdVal_o = mem_q[rd_ptr_q + PTR_WIDTH'(i)][dataWidth-1:0];
      end
    end
  end
`else
  // Without forwarding, queued writes are observable only through the write port.
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Scoreboard bench for writeback_queue: driver pushes expected writes, negedge monitor compares.
module tb_writeback_queue;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [4:0]  addr;
    logic [63:0] val;
  } wb_t;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic [2:0]  functionalUnitCode_i;
  logic        reg1WritebackEnable_i, reg2WritebackEnable_i;
  logic [4:0]  reg1WritebackAddress_i, reg2WritebackAddress_i;
  logic [63:0] reg1WritebackVal_i, reg2WritebackVal_i;
  logic        condRegUpdateEnable_i;
  logic [31:0] newCRVal_i;
  logic        stall_o, regWriteEnable_o;
  logic [4:0]  regWriteAddress_o;
  logic [63:0] regWriteVal_o;
  logic [31:0] condReg_o;
  logic [3:0]  queueCount_o;
`ifdef WB_FORWARD_EN
  logic [4:0]  fwdAddress_i;
  logic        fwdHit_o;
  logic [63:0] fwdVal_o;
`endif

  wb_t         exp_q[$];
  logic [31:0] cr_model;
  logic [4:0]  last_addr;
  logic [63:0] last_val;
  logic [63:0] gpr [32];
  int          n_checks = 0;
  int          n_errors = 0;
  int          stall_seen = 0;
  bit          mon_en = 1'b0;

  writeback_queue #(
    .regWidth (5),
    .dataWidth(64),
    .DEPTH    (DEPTH),
    .PTR_WIDTH(3)
  ) dut (
    .clock_i               (clock_i),
    .reset_i               (reset_i),
    .functionalUnitCode_i  (functionalUnitCode_i),
    .reg1WritebackEnable_i (reg1WritebackEnable_i),
    .reg2WritebackEnable_i (reg2WritebackEnable_i),
    .reg1WritebackAddress_i(reg1WritebackAddress_i),
    .reg2WritebackAddress_i(reg2WritebackAddress_i),
    .reg1WritebackVal_i    (reg1WritebackVal_i),
    .reg2WritebackVal_i    (reg2WritebackVal_i),
    .condRegUpdateEnable_i (condRegUpdateEnable_i),
    .newCRVal_i            (newCRVal_i),
`ifdef WB_FORWARD_EN
    .fwdAddress_i          (fwdAddress_i),
    .fwdHit_o              (fwdHit_o),
    .fwdVal_o              (fwdVal_o),
`endif
    .stall_o               (stall_o),
    .regWriteEnable_o      (regWriteEnable_o),
    .regWriteAddress_o     (regWriteAddress_o),
    .regWriteVal_o         (regWriteVal_o),
    .condReg_o             (condReg_o),
    .queueCount_o          (queueCount_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One producer beat; the model decides acceptance from its own occupancy.
  task automatic beat(input logic e1, input logic [4:0] a1, input logic [63:0] v1,
                      input logic e2, input logic [4:0] a2, input logic [63:0] v2,
                      input logic cre, input logic [31:0] crv);
    bit stalled;
    reg1WritebackEnable_i  = e1;
    reg1WritebackAddress_i = a1;
    reg1WritebackVal_i     = v1;
    reg2WritebackEnable_i  = e2;
    reg2WritebackAddress_i = a2;
    reg2WritebackVal_i     = v2;
    condRegUpdateEnable_i  = cre;
    newCRVal_i             = crv;
    functionalUnitCode_i   = 3'($urandom_range(0, 7));
    stalled = exp_q.size() > DEPTH - 2;
    @(posedge clock_i);
    if (reset_i) begin
      exp_q.delete();
      cr_model  = '0;
      last_addr = '0;
      last_val  = '0;
    end else if (!stalled) begin
      if (e1) exp_q.push_back('{addr: a1, val: v1});
      if (e2) exp_q.push_back('{addr: a2, val: v2});
      if (cre) cr_model = crv;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 32'd0);
  endtask

  task automatic apply_reset();
    reset_i = 1'b1;
    idle(1);
    reset_i = 1'b0;
  endtask

  always @(negedge clock_i) begin : monitor
    int   sz;
    wb_t  e;
    logic f_hit;
    logic [63:0] f_val;
    if (mon_en) begin
      sz = exp_q.size();
      check("queue_count", 64'(queueCount_o), 64'(sz));
      check("stall", 64'(stall_o), 64'(sz > DEPTH - 2));
      check("write_enable", 64'(regWriteEnable_o), 64'(sz != 0));
      check("cond_reg", 64'(condReg_o), 64'(cr_model));
      if (stall_o) stall_seen++;
`ifdef WB_FORWARD_EN
      f_hit = 1'b0;
      f_val = '0;
      foreach (exp_q[i]) begin
        if (exp_q[i].addr == fwdAddress_i) begin
          f_hit = 1'b1;
          f_val = exp_q[i].val;
        end
      end
      check("fwd_hit", 64'(fwdHit_o), 64'(f_hit));
      check("fwd_val", fwdVal_o, f_val);
`endif
      if (regWriteEnable_o) gpr[regWriteAddress_o] = regWriteVal_o;
      if (sz != 0) begin
        e = exp_q.pop_front();
        last_addr = e.addr;
        last_val  = e.val;
      end
      check("write_addr", 64'(regWriteAddress_o), 64'(last_addr));
      check("write_val", regWriteVal_o, last_val);
    end
  end

  initial begin
    reset_i = 1'b1;
    cr_model = '0;
    last_addr = '0;
    last_val = '0;
`ifdef WB_FORWARD_EN
    fwdAddress_i = 5'd0;
`endif
    apply_reset();
    mon_en = 1'b1;
    idle(2);

    beat(1'b1, 5'd3, 64'h1234, 1'b0, 5'd0, 64'd0, 1'b0, 32'd0);
    idle(3);
    beat(1'b1, 5'd5, 64'hA, 1'b1, 5'd7, 64'hB, 1'b0, 32'd0);
    idle(3);
    beat(1'b1, 5'd9, 64'h11, 1'b1, 5'd9, 64'h22, 1'b0, 32'd0);
    idle(4);
    check("gpr_r9_final", gpr[9], 64'h22);
    beat(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 32'h8000_0002);
    idle(2);

    // Saturate with two-write beats; CR updates on stalled beats must be dropped.
    for (int i = 0; i < 14; i++)
      beat(1'b1, 5'($urandom_range(0, 31)), {$urandom, $urandom},
           1'b1, 5'($urandom_range(0, 31)), {$urandom, $urandom}, 1'b1, $urandom);
    check("stall_reached", 64'(stall_seen != 0), 64'd1);
    idle(10);

`ifdef WB_FORWARD_EN
    beat(1'b1, 5'd4, 64'h1, 1'b1, 5'd4, 64'h2, 1'b0, 32'd0);
    fwdAddress_i = 5'd4;
    #1;
    check("fwd_r4_hit", 64'(fwdHit_o), 64'd1);
    check("fwd_r4_val", fwdVal_o, 64'h2);
    fwdAddress_i = 5'd6;
    #1;
    check("fwd_r6_hit", 64'(fwdHit_o), 64'd0);
    check("fwd_r6_val", fwdVal_o, 64'd0);
    idle(3);
`endif

    for (int i = 0; i < 300; i++) begin
`ifdef WB_FORWARD_EN
      fwdAddress_i = 5'($urandom_range(0, 7));
`endif
      beat(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), {$urandom, $urandom},
           1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), {$urandom, $urandom},
           1'($urandom_range(0, 3) == 0), $urandom);
    end
    idle(10);

    // Reset with three entries pending: nothing further may be written.
    beat(1'b1, 5'd1, 64'h101, 1'b1, 5'd2, 64'h102, 1'b1, 32'h5555_AAAA);
    beat(1'b1, 5'd3, 64'h103, 1'b1, 5'd4, 64'h104, 1'b0, 32'd0);
    check("pending_before_reset", 64'(queueCount_o), 64'd3);
    apply_reset();
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
